// File: rtl/cond_flag_unit.sv
// rtl/cond_flag_unit.sv - NZCV flag register with parallel condition evaluation and flag stack
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   flags_we        flag register write strobe
//   flags_in        new flags {N,Z,C,V}
//   flags_mask      per-bit write enable for flags_in
//   cond_valid      condition evaluation request
//   cond_code       NUM_SLOTS packed 4-bit condition codes, slot k at [4k+3:4k]
//   cond_met        per-slot evaluation result
//   cond_met_valid  qualifier for cond_met
//   push, pop       save / restore committed flags on the flag stack
//   flags_out       committed flag register
//   stack_full      stack holds STACK_DEPTH entries
//   stack_empty     stack holds no entries
//   stack_err       one-cycle pulse after an illegal push/pop request

module cond_flag_unit #(
    parameter int NUM_SLOTS   = 2,
    parameter int STACK_DEPTH = 4,
    parameter int REG_OUT     = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flags_we,
    input  logic [3:0]             flags_in,
    input  logic [3:0]             flags_mask,
    input  logic                   cond_valid,
    input  logic [4*NUM_SLOTS-1:0] cond_code,
    output logic [NUM_SLOTS-1:0]   cond_met,
    output logic                   cond_met_valid,
    input  logic                   push,
    input  logic                   pop,
    output logic [3:0]             flags_out,
    output logic                   stack_full,
    output logic                   stack_empty,
    output logic                   stack_err
);

    localparam int AW = $clog2(STACK_DEPTH);
    localparam int DW = AW + 1;
    localparam logic [DW-1:0] DEPTH_MAX = DW'(STACK_DEPTH);

    logic [3:0]    flags_q;
    logic [DW-1:0] depth_q;
    logic [3:0]    stack_mem [STACK_DEPTH];
    logic          full_q;
    logic          empty_q;
    logic          err_q;

    logic          is_full;
    logic          is_empty;
    logic          push_ok;
    logic          pop_ok;
    logic          err_d;
    logic [DW-1:0] depth_m1;
    logic [DW-1:0] depth_d;
    logic [AW-1:0] wr_idx;
    logic [AW-1:0] rd_idx;
    logic [3:0]    base;
    logic [3:0]    eff;
    logic [NUM_SLOTS-1:0] eval_vec;

    function automatic logic eval_cond(input logic [3:0] code, input logic [3:0] f);
        logic n, z, c, v;
        logic r;
        n = f[3];
        z = f[2];
        c = f[1];
        v = f[0];
        case (code)
            4'h0:    r = z;
            4'h1:    r = ~z;
            4'h2:    r = c;
            4'h3:    r = ~c;
            4'h4:    r = n;
            4'h5:    r = ~n;
            4'h6:    r = v;
            4'h7:    r = ~v;
            4'h8:    r = c & ~z;
            4'h9:    r = ~c | z;
            4'hA:    r = (n == v);
            4'hB:    r = (n != v);
            4'hC:    r = ~z & (n == v);
            4'hD:    r = z | (n != v);
            4'hE:    r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    always_comb begin
        is_full  = (depth_q == DEPTH_MAX);
        is_empty = (depth_q == '0);
        // Simultaneous push and pop is rejected outright rather than treated as a swap.
        push_ok  = push & ~pop & ~is_full;
        pop_ok   = pop & ~push & ~is_empty;
        err_d    = (push & pop) | (push & ~pop & is_full) | (pop & ~push & is_empty);
        depth_m1 = depth_q - DW'(1);
        wr_idx   = depth_q[AW-1:0];
        rd_idx   = depth_m1[AW-1:0];
        base     = pop_ok ? stack_mem[rd_idx] : flags_q;
        eff      = flags_we ? ((base & ~flags_mask) | (flags_in & flags_mask)) : base;
        if (push_ok) begin
            depth_d = depth_q + DW'(1);
        end else if (pop_ok) begin
            depth_d = depth_m1;
        end else begin
            depth_d = depth_q;
        end
    end

    always_comb begin
        eval_vec = '0;
        for (int k = 0; k < NUM_SLOTS; k++) begin
            eval_vec[k] = eval_cond(cond_code[4*k +: 4], eff);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags_q <= '0;
            depth_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            err_q   <= 1'b0;
        end else begin
            flags_q <= eff;
            depth_q <= depth_d;
            full_q  <= (depth_d == DEPTH_MAX);
            empty_q <= (depth_d == '0);
            err_q   <= err_d;
        end
    end

    // Stack contents are not reset; a push saves the committed value, not this cycle's write.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            stack_mem[wr_idx] <= flags_q;
        end
    end

    generate
        if (REG_OUT != 0) begin : g_reg_out
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cond_met       <= '0;
                    cond_met_valid <= 1'b0;
                end else begin
                    cond_met_valid <= cond_valid;
                    if (cond_valid) begin
                        cond_met <= eval_vec;
                    end
                end
            end
        end else begin : g_comb_out
            assign cond_met       = rst ? '0 : eval_vec;
            assign cond_met_valid = ~rst & cond_valid;
        end
    endgenerate

    assign flags_out   = flags_q;
    assign stack_full  = full_q;
    assign stack_empty = empty_q;
    assign stack_err   = err_q;

endmodule

// File: tb/tb_cond_flag_unit.sv
// tb/tb_cond_flag_unit.sv - self-checking bench for cond_flag_unit

module tb_cond_flag_unit;

    localparam int SD = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       flags_we;
    logic [3:0] flags_in;
    logic [3:0] flags_mask;
    logic       cond_valid;
    logic [7:0] cond_code;
    logic [1:0] cond_met;
    logic       cond_met_valid;
    logic       push;
    logic       pop;
    logic [3:0] flags_out;
    logic       stack_full;
    logic       stack_empty;
    logic       stack_err;

    int checks = 0;
    int errors = 0;

    int m_flags;
    int m_q[$];
    int m_met;
    int m_valid;
    int m_err;

    cond_flag_unit #(.NUM_SLOTS(2), .STACK_DEPTH(SD), .REG_OUT(1)) dut (
        .clk            (clk),
        .rst            (rst),
        .flags_we       (flags_we),
        .flags_in       (flags_in),
        .flags_mask     (flags_mask),
        .cond_valid     (cond_valid),
        .cond_code      (cond_code),
        .cond_met       (cond_met),
        .cond_met_valid (cond_met_valid),
        .push           (push),
        .pop            (pop),
        .flags_out      (flags_out),
        .stack_full     (stack_full),
        .stack_empty    (stack_empty),
        .stack_err      (stack_err)
    );

    always #5 clk = ~clk;

    // Codes come in complementary pairs: odd code = negation of the even one.
    function automatic int ref_eval(input int code, input int f);
        int n, z, c, v, b;
        n = (f >> 3) & 1;
        z = (f >> 2) & 1;
        c = (f >> 1) & 1;
        v = f & 1;
        case (code >> 1)
            0: b = z;
            1: b = c;
            2: b = n;
            3: b = v;
            4: b = (c == 1 && z == 0) ? 1 : 0;
            5: b = (n == v) ? 1 : 0;
            6: b = (z == 0 && n == v) ? 1 : 0;
            default: b = 1;
        endcase
        return b ^ (code & 1);
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_flags = 0;
        m_q.delete();
        m_met   = 0;
        m_valid = 0;
        m_err   = 0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".flags_out"}, 8'(flags_out), 8'(m_flags));
        chk({tag, ".stack_full"}, 8'(stack_full), 8'(m_q.size() == SD));
        chk({tag, ".stack_empty"}, 8'(stack_empty), 8'(m_q.size() == 0));
        chk({tag, ".stack_err"}, 8'(stack_err), 8'(m_err));
        chk({tag, ".cond_met_valid"}, 8'(cond_met_valid), 8'(m_valid));
        chk({tag, ".cond_met"}, 8'(cond_met), 8'(m_met));
    endtask

    task automatic step(input string tag, input int we, input int fin, input int mask,
                        input int cv, input int codes, input int pu, input int po);
        int base, eff, sz;
        flags_we   = 1'(we);
        flags_in   = 4'(fin);
        flags_mask = 4'(mask);
        cond_valid = 1'(cv);
        cond_code  = 8'(codes);
        push       = 1'(pu);
        pop        = 1'(po);
        sz = m_q.size();
        m_err = ((pu != 0 && po != 0) || (pu != 0 && po == 0 && sz == SD) ||
                 (po != 0 && pu == 0 && sz == 0)) ? 1 : 0;
        base = (po != 0 && pu == 0 && sz > 0) ? m_q[sz-1] : m_flags;
        eff  = (we != 0) ? ((base & ~mask) | (fin & mask)) & 15 : base;
        if (pu != 0 && po == 0 && sz < SD) m_q.push_back(m_flags);
        if (po != 0 && pu == 0 && sz > 0) void'(m_q.pop_back());
        m_flags = eff;
        m_valid = (cv != 0) ? 1 : 0;
        if (cv != 0) begin
            m_met = 0;
            for (int k = 0; k < 2; k++) m_met |= ref_eval((codes >> (4*k)) & 15, eff) << k;
        end
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    initial begin
        model_reset();
        rst = 1'b1;
        flags_we = 0; flags_in = 0; flags_mask = 0; cond_valid = 0; cond_code = 0;
        push = 0; pop = 0;
        #2;
        check_all("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Full write, EQ/NE on the same cycle
        step("wr_eq_ne", 1, 4'b0100, 4'hF, 1, 8'h10, 0, 0);
        chk("tp_eq_ne", 8'(cond_met), 8'b01);
        chk("tp_flags0100", 8'(flags_out), 8'b0100);

        // Masked write
        step("set1111", 1, 4'hF, 4'hF, 0, 0, 0, 0);
        step("masked", 1, 4'b0000, 4'b0010, 1, 8'h82, 0, 0);
        chk("tp_masked_flags", 8'(flags_out), 8'b1101);
        chk("tp_cs_hi", 8'(cond_met), 8'b00);

        // Signed compares
        step("ge_lt", 1, 4'b1000, 4'hF, 1, 8'hBA, 0, 0);
        chk("tp_ge_lt", 8'(cond_met), 8'b10);
        step("gt_le", 0, 0, 0, 1, 8'hDC, 0, 0);
        chk("tp_gt_le", 8'(cond_met), 8'b10);
        step("hold", 0, 0, 0, 0, 8'h00, 0, 0);
        chk("tp_hold", 8'(cond_met), 8'b10);

        // Fill the stack with writes between the pushes
        step("w1", 1, 4'b0001, 4'hF, 0, 0, 0, 0);
        step("p1", 1, 4'b0010, 4'hF, 0, 0, 1, 0);
        step("p2", 1, 4'b0011, 4'hF, 0, 0, 1, 0);
        step("p3", 1, 4'b0100, 4'hF, 0, 0, 1, 0);
        step("p4", 0, 0, 0, 0, 0, 1, 0);
        chk("tp_full", 8'(stack_full), 8'd1);
        step("p5_over", 0, 0, 0, 0, 0, 1, 0);
        chk("tp_over_err", 8'(stack_err), 8'd1);
        step("pop1", 0, 0, 0, 0, 0, 0, 1);
        chk("tp_pop1", 8'(flags_out), 8'b0100);
        step("pop2", 0, 0, 0, 0, 0, 0, 1);
        chk("tp_pop2", 8'(flags_out), 8'b0011);
        step("pop3", 0, 0, 0, 0, 0, 0, 1);
        chk("tp_pop3", 8'(flags_out), 8'b0010);
        step("pop4", 0, 0, 0, 0, 0, 0, 1);
        chk("tp_pop4", 8'(flags_out), 8'b0001);
        chk("tp_empty", 8'(stack_empty), 8'd1);
        step("pop_under", 0, 0, 0, 0, 0, 0, 1);
        chk("tp_under_err", 8'(stack_err), 8'd1);
        chk("tp_under_flags", 8'(flags_out), 8'b0001);

        // Pop with a same-cycle masked write, evaluated through the bypass
        step("w0110", 1, 4'b0110, 4'hF, 0, 0, 0, 0);
        step("push0110", 1, 4'b0000, 4'hF, 0, 0, 1, 0);
        step("pop_wr", 1, 4'b1000, 4'b1000, 1, 8'hF4, 0, 1);
        chk("tp_pop_wr_flags", 8'(flags_out), 8'b1110);
        chk("tp_pop_wr_mi", 8'(cond_met[0]), 8'd1);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            int r;
            r = int'($urandom_range(0, 9));
            step("rand", int'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
                 int'($urandom_range(0, 15)), int'($urandom_range(0, 1)),
                 int'($urandom_range(0, 255)), (r < 3 || r == 9) ? 1 : 0,
                 (r >= 3 && r < 6) || r == 9 ? 1 : 0);
        end

        // Asynchronous reset between clock edges
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check_all("async_rst1");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Simultaneous push/pop at depth 2, then reset mid-sequence
        step("d_w1", 1, 4'b0101, 4'hF, 0, 0, 0, 0);
        step("d_p1", 1, 4'b1010, 4'hF, 0, 0, 1, 0);
        step("d_p2", 0, 0, 0, 0, 0, 1, 0);
        step("d_both", 0, 0, 0, 1, 8'hE1, 1, 1);
        chk("tp_both_err", 8'(stack_err), 8'd1);
        chk("tp_both_depth", 8'(m_q.size()), 8'd2);
        chk("tp_both_empty", 8'(stack_empty), 8'd0);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check_all("async_rst2");
        chk("tp_rst_valid", 8'(cond_met_valid), 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cond_flag_unit.md
Name: cond_flag_unit

Overview:
- Parametrised successor to the single-slot condition checker.
- Holds the architectural NZCV flag register, with per-bit masked update from the ALU.
- Evaluates NUM_SLOTS condition codes per cycle against the effective flags, with same-cycle write bypass.
- Provides a flag save/restore stack for interrupt/call entry and exit; sits between the ALU and the issue/branch stage.

Parameters:
- NUM_SLOTS, 2, number of condition codes evaluated in parallel (1..4).
- STACK_DEPTH, 4, flag stack entries (power of 2, 2..16).
- REG_OUT, 1, 1 = registered evaluation result (1-cycle latency); 0 = combinational.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- flags_we  in  1  flag register write strobe.
- flags_in  in  4  new flags {N,Z,C,V} (bit3=N, bit2=Z, bit1=C, bit0=V).
- flags_mask  in  4  per-bit write enable, same bit order; ignored when flags_we=0.
- cond_valid  in  1  condition evaluation request.
- cond_code  in  4*NUM_SLOTS  slot k code in bits [4k+3:4k].
- cond_met  out  NUM_SLOTS  per-slot result.
- cond_met_valid  out  1  cond_met qualifier.
- push  in  1  save committed flags to stack.
- pop  in  1  restore flags from stack.
- flags_out  out  4  committed flag register.
- stack_full  out  1  depth == STACK_DEPTH.
- stack_empty  out  1  depth == 0.
- stack_err  out  1  registered 1-cycle error pulse.

Behaviour:
- Reset (async, any time, including mid-push/pop): flags_out=0000, stack depth 0, stack_empty=1, stack_full=0, stack_err=0, cond_met=0, cond_met_valid=0. Stack contents are don't-care.
- Condition encoding per slot:
  - 0 EQ: Z.
  - 1 NE: !Z.
  - 2 CS: C.
  - 3 CC: !C.
  - 4 MI: N.
  - 5 PL: !N.
  - 6 VS: V.
  - 7 VC: !V.
  - 8 HI: C&!Z.
  - 9 LS: !C|Z.
  - A GE: N==V.
  - B LT: N!=V.
  - C GT: !Z&(N==V).
  - D LE: Z|(N!=V).
  - E AL: 1.
  - F NV: 0.
- Effective flags, computed per cycle:
  - base = popped entry if a legal pop is performed, else flags_out.
  - eff = flags_we ? (base & ~mask) | (flags_in & mask) : base.
  - Register update: flags_out <= eff.
- Bypass: conditions are evaluated on eff, so a same-cycle ALU write or pop is visible to evaluation.
- REG_OUT=1:
  - cond_met <= eval(eff); cond_met_valid <= cond_valid.
  - Result appears the cycle after the request.
  - When cond_valid=0, cond_met holds its last value.
- REG_OUT=0: cond_met and cond_met_valid are combinational from the same cycle's inputs.
- Push (legal when not full): stack[depth] <= flags_out (the pre-write committed value, not eff); depth+1.
- Pop (legal when not empty): returns stack[depth-1]; depth-1.
- Error conditions (stack_err=1 next cycle; stack and depth unchanged; flags_we still applies):
  - push while full: entry dropped.
  - pop while empty: base = flags_out.
  - push and pop in the same cycle: neither is performed.
- stack_full and stack_empty are registered, derived from depth after the update.
- Back-to-back push/pop on consecutive cycles is supported at full rate.

Test Plan:
- Reset, then flags_we=1, mask=1111, flags_in=0100, cond_valid=1, codes {0x0,0x1} in the same cycle:
  - REG_OUT=1: next cycle cond_met=01 (slot0 EQ=1, slot1 NE=0), cond_met_valid=1, flags_out=0100.
- Masked write: flags_out=1111; write flags_in=0000 with mask=0010:
  - flags_out=1101.
  - Evaluating 0x2 (CS) that cycle gives 0; 0x8 (HI) gives 0.
- Signed compare: flags N=1, V=0, Z=0, codes {0xA,0xB}, then {0xC,0xD}:
  - results 10 (GE=0, LT=1), then 10 (GT=0, LE=1).
- Stack, STACK_DEPTH=4: push flags 0001, 0010, 0011, 0100 on consecutive cycles with writes in between:
  - stack_full=1.
  - A fifth push gives stack_err pulse; depth stays 4.
  - Four pops restore 0100, 0011, 0010, 0001 in order, then stack_empty=1.
  - A further pop gives stack_err; flags unchanged.
- Pop with flags_we=1, mask=1000, flags_in=1000, popped entry 0110:
  - flags_out=1110.
  - Same-cycle code 0x4 (MI) evaluates 1.
- push=pop=1 with depth 2: stack_err=1, depth stays 2. Then assert rst mid-sequence: all outputs reset immediately, without waiting for a clock edge.
